// File: rtl/logic_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : logic_seq_ctrl_pkg
// Description : Shared operation and state encodings for the logic ALU blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package logic_seq_ctrl_pkg;

    localparam int C_OP_W = 2;

    typedef enum logic [C_OP_W-1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_NAND = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage
`default_nettype wire

// File: rtl/logic_seq_ctrl_slice.sv
`default_nettype none
// ============================================================================
// Module      : logic_slice
// Description : SLICE-bit bitwise logic unit built from per-bit gate primitives.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_slice
    import logic_seq_ctrl_pkg::*;
#(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0]  a,
    input  logic [SLICE-1:0]  b,
    input  logic [C_OP_W-1:0] op,
    output logic [SLICE-1:0]  result
);

    for (genvar i = 0; i < SLICE; i++) begin : g_bit
        logic w_and;
        logic w_or;
        logic w_xor;
        logic w_nand;

        and  u_and  (w_and,  a[i], b[i]);
        or   u_or   (w_or,   a[i], b[i]);
        xor  u_xor  (w_xor,  a[i], b[i]);
        nand u_nand (w_nand, a[i], b[i]);

        assign result[i] = (op == OP_AND) ? w_and :
                           (op == OP_OR)  ? w_or  :
                           (op == OP_XOR) ? w_xor : w_nand;
    end

endmodule
`default_nettype wire

// File: rtl/logic_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : logic_seq_ctrl
// Description : Slice-serial bitwise ALU: one SLICE-bit chunk per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_seq_ctrl
    import logic_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        op,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic              zero,
    output logic              busy
);

    localparam int N     = WIDTH / SLICE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    state_e             r_state_q,  w_state_d;
    logic [CNT_W-1:0]   r_cnt_q,    w_cnt_d;
    logic [WIDTH-1:0]   r_a_q,      w_a_d;
    logic [WIDTH-1:0]   r_b_q,      w_b_d;
    op_e                r_op_q,     w_op_d;
    logic [WIDTH-1:0]   r_result_q, w_result_d;
    logic               r_zero_q,   w_zero_d;

    logic [SLICE-1:0]   w_a_slice;
    logic [SLICE-1:0]   w_b_slice;
    logic [SLICE-1:0]   w_slice_res;

    always_comb begin
        w_a_slice = '0;
        w_b_slice = '0;
        for (int i = 0; i < N; i++) begin
            if (r_cnt_q == CNT_W'(i)) begin
                w_a_slice = r_a_q[i*SLICE +: SLICE];
                w_b_slice = r_b_q[i*SLICE +: SLICE];
            end
        end
    end

    logic_slice #(
        .SLICE (SLICE)
    ) u_logic_slice (
        .a      (w_a_slice),
        .b      (w_b_slice),
        .op     (r_op_q),
        .result (w_slice_res)
    );

    always_comb begin
        w_state_d  = r_state_q;
        w_cnt_d    = r_cnt_q;
        w_a_d      = r_a_q;
        w_b_d      = r_b_q;
        w_op_d     = r_op_q;
        w_result_d = r_result_q;
        w_zero_d   = r_zero_q;

        case (r_state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    w_a_d      = a;
                    w_b_d      = b;
                    w_op_d     = op_e'(op);
                    w_cnt_d    = '0;
                    w_result_d = '0;
                    w_zero_d   = 1'b0;
                    w_state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                for (int i = 0; i < N; i++) begin
                    if (r_cnt_q == CNT_W'(i)) begin
                        w_result_d[i*SLICE +: SLICE] = w_slice_res;
                    end
                end
                if (r_cnt_q == CNT_W'(N - 1)) begin
                    // zero is captured together with the last slice so it is valid on DONE entry
                    w_zero_d  = (w_result_d == '0);
                    w_cnt_d   = '0;
                    w_state_d = ST_DONE;
                end else begin
                    w_cnt_d = r_cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_zero_d  = 1'b0;
                    w_state_d = ST_IDLE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= ST_IDLE;
            r_cnt_q    <= '0;
            r_a_q      <= '0;
            r_b_q      <= '0;
            r_op_q     <= OP_AND;
            r_result_q <= '0;
            r_zero_q   <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_cnt_q    <= w_cnt_d;
            r_a_q      <= w_a_d;
            r_b_q      <= w_b_d;
            r_op_q     <= w_op_d;
            r_result_q <= w_result_d;
            r_zero_q   <= w_zero_d;
        end
    end

    assign in_ready  = (r_state_q == ST_IDLE);
    assign out_valid = (r_state_q == ST_DONE);
    assign busy      = (r_state_q == ST_RUN) || (r_state_q == ST_DONE);
    assign result    = r_result_q;
    assign zero      = r_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_logic_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_logic_seq_ctrl
// Description : Self-checking bench for logic_seq_ctrl against a word-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_seq_ctrl;

    localparam int WIDTH = 32;
    localparam int SLICE = 8;
    localparam int N     = WIDTH / SLICE;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    logic_seq_ctrl #(
        .WIDTH (WIDTH),
        .SLICE (SLICE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    function automatic logic [WIDTH-1:0] ref_op(input logic [1:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        case (o)
            2'b00:   return x & y;
            2'b01:   return x | y;
            2'b10:   return x ^ y;
            default: return ~(x & y);
        endcase
    endfunction

    // Starts and ends on a negedge with the DUT idle.
    task automatic run_txn(input logic [1:0] t_op, input logic [WIDTH-1:0] t_a, input logic [WIDTH-1:0] t_b,
                           input int hold, input bit scramble,
                           output int lat, output logic [WIDTH-1:0] res, output logic zr, output bit stable);
        int guard;
        in_valid = 1'b1; op = t_op; a = t_a; b = t_b;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        if (scramble) begin
            a  = '0;
            b  = $urandom;
            op = 2'($urandom_range(0, 3));
        end
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) lat = -1;
        res = result;
        zr = zero;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            @(negedge clk);
            if (!out_valid || result !== res || zero !== zr || in_ready) stable = 1'b0;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({in_ready, out_valid, busy, zero} !== 4'b1000 || result !== '0) begin
            n_fail++;
            $display("FAIL reset: rdy/ov/busy/zero=%b result=%h, expected 1000 result=00000000",
                     {in_ready, out_valid, busy, zero}, result);
        end
    endtask

    task automatic test_and_progress();
        logic [WIDTH-1:0] exp;
        logic [63:0]      mask;
        exp = ref_op(2'b00, 32'hF0F01234, 32'hFF00FF00);
        in_valid = 1'b1; op = 2'b00; a = 32'hF0F01234; b = 32'hFF00FF00;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            mask = (64'd1 << (k * SLICE)) - 64'd1;
            n_checks++;
            if (result !== (exp & mask[WIDTH-1:0]) || out_valid !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL and_partial k=%0d: result=%h ov=%b busy=%b, expected result=%h ov=0 busy=1",
                         k, result, out_valid, busy, exp & mask[WIDTH-1:0]);
            end
            @(negedge clk);
        end
        n_checks++;
        if (out_valid !== 1'b1 || result !== 32'hF0001200 || zero !== 1'b0) begin
            n_fail++;
            $display("FAIL and_done: ov=%b result=%h zero=%b, expected ov=1 result=f0001200 zero=0",
                     out_valid, result, zero);
        end
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'hF0001200 || zero !== 1'b0) begin
            n_fail++;
            $display("FAIL and_idle: rdy=%b ov=%b result=%h zero=%b, expected rdy=1 ov=0 result=f0001200 zero=0",
                     in_ready, out_valid, result, zero);
        end
    endtask

    task automatic test_xor_zero();
        int lat; logic [WIDTH-1:0] res; logic zr; bit st;
        run_txn(2'b10, 32'hDEADBEEF, 32'hDEADBEEF, 0, 1'b0, lat, res, zr, st);
        n_checks++;
        if (lat !== N || res !== 32'h0 || zr !== 1'b1) begin
            n_fail++;
            $display("FAIL xor_zero: lat=%0d result=%h zero=%b, expected lat=%0d result=00000000 zero=1",
                     lat, res, zr, N);
        end
    endtask

    task automatic test_or_backpressure();
        int guard; int bad_rdy; logic [WIDTH-1:0] res;
        logic [WIDTH-1:0] exp2;
        exp2 = ref_op(2'b01, 32'h12340000, 32'h00005678);
        in_valid = 1'b1; op = 2'b01; a = 32'h0000000F; b = 32'hF0000000;
        @(negedge clk);
        op = 2'b01; a = 32'h12340000; b = 32'h00005678;
        bad_rdy = 0; guard = 0;
        while (!out_valid && guard < 20) begin
            if (in_ready) bad_rdy++;
            @(negedge clk);
            guard++;
        end
        res = result;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (in_ready || !out_valid || result !== res) bad_rdy++;
        end
        n_checks++;
        if (guard !== N || res !== 32'hF000000F || bad_rdy != 0) begin
            n_fail++;
            $display("FAIL or_hold: lat=%0d result=%h violations=%0d, expected lat=%0d result=f000000f violations=0",
                     guard, res, bad_rdy, N);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL or_idle_gap: rdy=%b ov=%b busy=%b, expected 1 0 0", in_ready, out_valid, busy);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL or_second_accept: busy=%b rdy=%b, expected busy=1 rdy=0", busy, in_ready);
        end
        guard = 0;
        while (!out_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (out_valid !== 1'b1 || result !== exp2) begin
            n_fail++;
            $display("FAIL or_second_result: ov=%b result=%h, expected ov=1 result=%h", out_valid, result, exp2);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_nand_reset();
        int lat; logic [WIDTH-1:0] res; logic zr; bit st; int seen;
        in_valid = 1'b1; op = 2'b11; a = 32'hFFFFFFFF; b = 32'h0;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({in_ready, out_valid, busy, zero} !== 4'b1000 || result !== '0) begin
            n_fail++;
            $display("FAIL nand_reset_state: rdy/ov/busy/zero=%b result=%h, expected 1000 result=00000000",
                     {in_ready, out_valid, busy, zero}, result);
        end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        out_ready = 1'b0;
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL nand_no_delivery: out_valid cycles=%0d, expected 0", seen);
        end
        run_txn(2'b11, 32'hFFFFFFFF, 32'h0, 1, 1'b0, lat, res, zr, st);
        n_checks++;
        if (lat !== N || res !== 32'hFFFFFFFF || zr !== 1'b0 || !st) begin
            n_fail++;
            $display("FAIL nand_reissue: lat=%0d result=%h zero=%b stable=%0d, expected lat=%0d result=ffffffff zero=0 stable=1",
                     lat, res, zr, st, N);
        end
    endtask

    task automatic test_operand_change();
        int lat; logic [WIDTH-1:0] res; logic zr; bit st;
        run_txn(2'b00, 32'h12345678, 32'hFFFFFFFF, 0, 1'b1, lat, res, zr, st);
        n_checks++;
        if (lat !== N || res !== 32'h12345678) begin
            n_fail++;
            $display("FAIL operand_change: lat=%0d result=%h, expected lat=%0d result=12345678", lat, res, N);
        end
    endtask

    task automatic test_random();
        int lat; logic [WIDTH-1:0] res; logic zr; bit st;
        logic [1:0] r_op; logic [WIDTH-1:0] r_a, r_b, exp;
        for (int t = 0; t < 40; t++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = $urandom;
            case ($urandom_range(0, 3))
                0:       r_b = r_a;
                1:       r_b = ~r_a;
                default: r_b = $urandom;
            endcase
            exp = ref_op(r_op, r_a, r_b);
            run_txn(r_op, r_a, r_b, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), lat, res, zr, st);
            n_checks++;
            if (lat !== N || res !== exp || zr !== (exp == '0) || !st) begin
                n_fail++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: lat=%0d result=%h zero=%b stable=%0d, expected lat=%0d result=%h zero=%b stable=1",
                         t, r_op, r_a, r_b, lat, res, zr, st, N, exp, (exp == '0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_and_progress();
        test_xor_zero();
        test_or_backpressure();
        test_nand_reset();
        test_operand_change();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/logic_seq_ctrl.md
LOGIC_SEQ_CTRL -- requirements
Module: logic_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning total operand/result width in bits.
REQ-002 SHALL have parameter SLICE, default 8, meaning bits processed per cycle; WIDTH is an integer multiple of SLICE; N = WIDTH/SLICE.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port op  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 NAND.
REQ-008 SHALL have port a  input  WIDTH  operand A.
REQ-009 SHALL have port b  input  WIDTH  operand B.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have port result  output  WIDTH  bitwise result.
REQ-013 SHALL have port zero  output  1  result == 0, qualified by out_valid.
REQ-014 SHALL have port busy  output  1  high in RUN or DONE.

Function
REQ-015 SHALL implement states IDLE, RUN, DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-016 Accept SHALL occur on an edge with in_valid && in_ready: latch a, b, op; clear slice counter cnt; clear result; go to RUN.
REQ-017 In RUN, each cycle SHALL apply op to slice cnt (bits cnt*SLICE+SLICE-1 : cnt*SLICE) of latched a, b via one shared SLICE-bit logic unit, write that result slice at the edge, and increment cnt.
REQ-018 RUN SHALL go to DONE on the edge where cnt == N-1; out_valid first high exactly N cycles after the accept edge.
REQ-019 Result bits not yet processed SHALL read 0 during RUN; result SHALL be final and stable throughout DONE.
REQ-020 zero SHALL be registered alongside the final slice write and equal (result == 0) while in DONE; 0 otherwise.
REQ-021 DONE SHALL go to IDLE on the edge with out_ready high; out_valid and result SHALL hold while out_ready is low (indefinite backpressure).
REQ-022 result SHALL keep its last value in IDLE until the next accept.
REQ-023 in_valid asserted while busy SHALL be ignored (not queued); the requester holds it until in_ready.
REQ-024 A new request SHALL NOT be accepted on the same edge DONE exits; earliest next accept is the following edge (one idle cycle minimum).
REQ-025 Changes to a, b, op after accept SHALL NOT affect the result in flight.
REQ-026 With N == 1, SHALL go IDLE -> RUN -> DONE, out_valid one cycle after accept.

Reset
REQ-027 rst high at an edge SHALL force IDLE, cnt = 0, result = 0, zero = 0, out_valid = 0, busy = 0, in_ready = 1, overriding any other event on that edge.
REQ-028 Reset mid-RUN or in DONE SHALL abandon the operation with no result delivered; the first post-reset request SHALL complete correctly.

Structure
REQ-029 Op encodings and state encodings SHALL reside in a shared package/include used by all ALU blocks.
REQ-030 SHALL instantiate exactly one sub-module, logic_slice (parameterized width SLICE, inputs a, b, op, output result), built from per-bit gate primitives in a generate loop; no other combinational logic on the operand path.

Verification (WIDTH=32, SLICE=8, N=4)
REQ-031 Reset: rst high 2 cycles -> in_ready=1, out_valid=0, busy=0, result=0x00000000, zero=0.
REQ-032 AND a=0xF0F01234 b=0xFF00FF00, out_ready=1 -> out_valid on 4th cycle after accept, result=0xF0001200, zero=0, back to IDLE one cycle later.
REQ-033 XOR a=b=0xDEADBEEF -> result=0x00000000, zero=1 with out_valid.
REQ-034 OR a=0x0000000F b=0xF0000000, out_ready low 5 cycles in DONE, second in_valid held -> result=0xF000000F stable, in_ready=0, second request accepted only after out_ready handshake plus one IDLE cycle.
REQ-035 NAND a=0xFFFFFFFF b=0x00000000, rst pulsed 2 cycles after accept -> IDLE, result=0, no out_valid; reissued request -> result=0xFFFFFFFF.
REQ-036 Operand change after accept: accept AND 0x12345678/0xFFFFFFFF, then drive a=0 -> result=0x12345678.
